// File: rtl/compositor_pkg.sv
// compositor_pkg: shared types for the layer compositor.
// Layer index, pixel and priority-table entry definitions.
package compositor_pkg;

  localparam int LIDX_W = 4;
  localparam int PIX_W  = 8;

  typedef logic [LIDX_W-1:0] lidx_t;
  typedef logic [PIX_W-1:0]  rgb_t;

  localparam rgb_t TRANSPARENT_DEF = 8'hFF;

  // vld=0 marks an empty rank
  typedef struct packed {
    logic  vld;
    lidx_t idx;
  } prio_entry_t;

  localparam prio_entry_t PRIO_EMPTY = '{vld: 1'b0, idx: '0};

  function automatic prio_entry_t prio_entry(
    input lidx_t idx,
    input logic  in_range
  );
    prio_entry_t e;
    e = in_range ? '{vld: 1'b1, idx: idx} : PRIO_EMPTY;
    return e;
  endfunction

endpackage

// File: rtl/layer_collision_tracker.sv
// layer_collision_tracker: per-frame overlap accumulator.
// Reports the layers that overlapped during the previous frame.
module layer_collision_tracker #(
  parameter int N_LAYERS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_LAYERS-1:0] eff_mask,
  input  logic                frame_pulse,
  output logic [N_LAYERS-1:0] acc,
  output logic [N_LAYERS-1:0] mask,
  output logic                valid
);

  logic [N_LAYERS-1:0] acc_q, acc_d;
  logic [N_LAYERS-1:0] mask_q, mask_d;
  logic                valid_q, valid_d;
  logic                multi;

  // Frame pulse publishes the old interval; this pixel starts the new one
  always_comb begin
    multi   = ($countones(eff_mask) >= 2);
    acc_d   = frame_pulse ? '0 : acc_q;
    mask_d  = frame_pulse ? acc_q : mask_q;
    valid_d = frame_pulse;
    if (multi) acc_d = acc_d | eff_mask;
  end

  // Accumulator, reported mask and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
    end
  end

  assign acc   = acc_q;
  assign mask  = mask_q;
  assign valid = valid_q;

endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: 2-stage priority compositor with colour key.
// Collision reporting is built only when LAYER_COLLISION_EN is defined.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int N_LAYERS = 8,
  parameter int RGB_W    = 8,
  parameter logic [RGB_W-1:0] TRANSPARENT_RGB =
    RGB_W'(TRANSPARENT_DEF)
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic [N_LAYERS-1:0]             drawReq,
  input  logic [N_LAYERS-1:0][RGB_W-1:0]  layerRGB,
  input  logic [RGB_W-1:0]                backGroundRGB,
  input  logic                            startOfFrame,
  input  logic                            prioWr,
  input  logic [$clog2(N_LAYERS)-1:0]     prioRank,
  input  logic [$clog2(N_LAYERS)-1:0]     prioLayer,
  output logic [RGB_W-1:0]                RGBOut,
  output logic [N_LAYERS-1:0]             collisionMask,
  output logic                            collisionValid
);

  localparam int IW = $clog2(N_LAYERS);

  typedef prio_entry_t [N_LAYERS-1:0] table_t;

  table_t shadow_q, shadow_d;
  table_t active_q, active_d;

  logic [N_LAYERS-1:0]            eff_q, eff_d;
  logic [N_LAYERS-1:0][RGB_W-1:0] rgb_q;
  logic [RGB_W-1:0]               bg_q;
  logic [RGB_W-1:0]               rgb_out_q, rgb_out_d;

`ifdef LAYER_COLLISION_EN
  logic                sof_q, sof_d;
  logic [N_LAYERS-1:0] pres;
`endif

  // Stage 1: shadow write, frame commit, effective requests
  always_comb begin
    shadow_d = shadow_q;
    if (prioWr) begin
      for (int r = 0; r < N_LAYERS; r++) begin
        if (prioRank == IW'(r)) begin
          shadow_d[r] = prio_entry(
            lidx_t'(prioLayer),
            32'(prioLayer) < 32'(N_LAYERS));
        end
      end
    end
    active_d = startOfFrame ? shadow_d : active_q;
    for (int i = 0; i < N_LAYERS; i++) begin
      eff_d[i] = drawReq[i] &&
                 (layerRGB[i] != TRANSPARENT_RGB);
    end
`ifdef LAYER_COLLISION_EN
    sof_d = startOfFrame;
`endif
  end

  // Stage 1 registers; tables reset to identity order
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int r = 0; r < N_LAYERS; r++) begin
        shadow_q[r] <= '{vld: 1'b1, idx: lidx_t'(r)};
        active_q[r] <= '{vld: 1'b1, idx: lidx_t'(r)};
      end
      eff_q <= '0;
      rgb_q <= '0;
      bg_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      eff_q    <= eff_d;
      rgb_q    <= layerRGB;
      bg_q     <= backGroundRGB;
    end
  end

`ifdef LAYER_COLLISION_EN
  // Frame marker follows the pixel into stage 2
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) sof_q <= 1'b0;
    else         sof_q <= sof_d;
  end
`endif

  // Stage 2: scan ranks high to low so the lowest rank wins
  always_comb begin
    rgb_out_d = bg_q;
`ifdef LAYER_COLLISION_EN
    pres = '0;
`endif
    for (int r = N_LAYERS - 1; r >= 0; r--) begin
      for (int l = 0; l < N_LAYERS; l++) begin
        if (active_q[r].vld &&
            active_q[r].idx == lidx_t'(l) &&
            eff_q[l]) begin
          rgb_out_d = rgb_q[l];
`ifdef LAYER_COLLISION_EN
          pres[l] = 1'b1;
`endif
        end
      end
    end
  end

  // Output pixel register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) rgb_out_q <= '0;
    else         rgb_out_q <= rgb_out_d;
  end

  assign RGBOut = rgb_out_q;

`ifdef LAYER_COLLISION_EN
  logic [N_LAYERS-1:0] unused_acc;

  layer_collision_tracker #(
    .N_LAYERS(N_LAYERS)
  ) u_coll (
    .clk        (clk),
    .rst_n      (resetN),
    .eff_mask   (pres),
    .frame_pulse(sof_q),
    .acc        (unused_acc),
    .mask       (collisionMask),
    .valid      (collisionValid)
  );
`else
  assign collisionMask  = '0;
  assign collisionValid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: vector table plus scoreboard for the compositor.
// Collision expectations collapse to 0 when LAYER_COLLISION_EN is off.
module tb_layer_compositor;

  localparam int N = 4;
`ifdef LAYER_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif
  localparam logic [31:0] DEF = 32'h40302010;
  localparam logic [7:0]  BG  = 8'h0B;

  logic            clk = 1'b0;
  logic            resetN = 1'b0;
  logic [N-1:0]    drawReq = '0;
  logic [N-1:0][7:0] layerRGB = '0;
  logic [7:0]      backGroundRGB = '0;
  logic            startOfFrame = 1'b0;
  logic            prioWr = 1'b0;
  logic [1:0]      prioRank = '0;
  logic [1:0]      prioLayer = '0;
  logic [7:0]      RGBOut;
  logic [N-1:0]    collisionMask;
  logic            collisionValid;

  layer_compositor #(
    .N_LAYERS(N),
    .RGB_W(8),
    .TRANSPARENT_RGB(8'hFF)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .drawReq(drawReq),
    .layerRGB(layerRGB),
    .backGroundRGB(backGroundRGB),
    .startOfFrame(startOfFrame),
    .prioWr(prioWr),
    .prioRank(prioRank),
    .prioLayer(prioLayer),
    .RGBOut(RGBOut),
    .collisionMask(collisionMask),
    .collisionValid(collisionValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dr;
    logic [31:0] rgbs;
    logic        sof;
    logic        wr;
    logic [1:0]  rank;
    logic [1:0]  layer;
    logic [7:0]  rgb;
    logic        v;
    logic [3:0]  m;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] rgb;
    logic       v;
    logic [3:0] m;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;

  function automatic vec_t mk(
    input logic [3:0] dr, input logic [31:0] rgbs,
    input logic sof, input logic wr,
    input logic [1:0] rank, input logic [1:0] layer,
    input logic [7:0] rgb, input logic v, input logic [3:0] m);
    vec_t t;
    t = '{dr, rgbs, sof, wr, rank, layer, rgb, v, m};
    return t;
  endfunction

  task automatic check(input string name, input int id,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h",
               name, id, got, exp);
    end
  endtask

  task automatic step(input vec_t t);
    exp_t e;
    drawReq       = t.dr;
    layerRGB      = t.rgbs;
    backGroundRGB = BG;
    startOfFrame  = t.sof;
    prioWr        = t.wr;
    prioRank      = t.rank;
    prioLayer     = t.layer;
    sb.push_back('{step_id, t.rgb, COLL ? t.v : 1'b0,
                   COLL ? t.m : 4'b0000});
    step_id++;
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      check("rgb", e.id, 32'(RGBOut), 32'(e.rgb));
      check("cvalid", e.id, 32'(collisionValid), 32'(e.v));
      check("cmask", e.id, 32'(collisionMask), 32'(e.m));
    end
  endtask

  initial begin
    // priority, transparency and table swap vectors
    vecs.push_back(mk(4'b0110, DEF, 0, 0, 0, 0, 8'h20, 0, 4'h0));
    vecs.push_back(mk(4'b0011, 32'h403055FF, 0, 0, 0, 0, 8'h55, 0, 4'h0));
    vecs.push_back(mk(4'b0011, 32'h4030FFFF, 0, 0, 0, 0, BG, 0, 4'h0));
    vecs.push_back(mk(4'b0000, DEF, 0, 0, 0, 0, BG, 0, 4'h0));
    vecs.push_back(mk(4'b1000, DEF, 0, 0, 0, 0, 8'h40, 0, 4'h0));
    vecs.push_back(mk(4'b1001, DEF, 0, 1, 0, 3, 8'h10, 0, 4'h0));
    vecs.push_back(mk(4'b1001, DEF, 0, 1, 1, 2, 8'h10, 0, 4'h0));
    vecs.push_back(mk(4'b1001, DEF, 0, 1, 2, 1, 8'h10, 0, 4'h0));
    vecs.push_back(mk(4'b1001, DEF, 0, 1, 3, 0, 8'h10, 0, 4'h0));
    vecs.push_back(mk(4'b1001, DEF, 1, 0, 0, 0, 8'h40, 1, 4'hF));
    vecs.push_back(mk(4'b0110, DEF, 0, 0, 0, 0, 8'h30, 0, 4'hF));
    vecs.push_back(mk(4'b0011, DEF, 1, 1, 0, 1, 8'h20, 1, 4'hF));
    vecs.push_back(mk(4'b0101, DEF, 0, 0, 0, 0, 8'h30, 0, 4'hF));
    vecs.push_back(mk(4'b0001, DEF, 0, 0, 0, 0, 8'h10, 0, 4'hF));
    vecs.push_back(mk(4'b0001, DEF, 0, 1, 3, 2, 8'h10, 0, 4'hF));
    vecs.push_back(mk(4'b0001, DEF, 1, 0, 0, 0, BG, 1, 4'h7));
    vecs.push_back(mk(4'b1000, DEF, 0, 0, 0, 0, BG, 0, 4'h7));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rgb", -1, 32'(RGBOut), 32'h0);
    check("rst_cmask", -1, 32'(collisionMask), 32'h0);
    check("rst_cvalid", -1, 32'(collisionValid), 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) step(vecs[i]);

    // build a nonzero accumulator, then reset mid-frame
    step(mk(4'b0110, DEF, 0, 0, 0, 0, 8'h20, 0, 4'h7));
    step(mk(4'b0110, DEF, 0, 0, 0, 0, 8'h20, 0, 4'h7));
    resetN = 1'b0;
    #1;
    check("async_rgb", -2, 32'(RGBOut), 32'h0);
    check("async_cmask", -2, 32'(collisionMask), 32'h0);
    check("async_cvalid", -2, 32'(collisionValid), 32'h0);
    #2;
    resetN = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;

    // identity table restored, then collision frames
    step(mk(4'b0001, DEF, 0, 0, 0, 0, 8'h10, 0, 4'h0));
    step(mk(4'b1000, DEF, 0, 0, 0, 0, 8'h40, 0, 4'h0));
    step(mk(4'b0000, DEF, 1, 0, 0, 0, BG, 1, 4'h0));
    for (int k = 0; k < 3; k++)
      step(mk(4'b0110, DEF, 0, 0, 0, 0, 8'h20, 0, 4'h0));
    step(mk(4'b0100, DEF, 0, 0, 0, 0, 8'h30, 0, 4'h0));
    step(mk(4'b0000, DEF, 1, 0, 0, 0, BG, 1, 4'h6));
    step(mk(4'b0001, DEF, 0, 0, 0, 0, 8'h10, 0, 4'h6));
    step(mk(4'b1000, DEF, 0, 0, 0, 0, 8'h40, 0, 4'h6));
    step(mk(4'b0000, DEF, 1, 0, 0, 0, BG, 1, 4'h0));
    step(mk(4'b0000, DEF, 1, 0, 0, 0, BG, 1, 4'h0));
    step(mk(4'b0000, DEF, 0, 0, 0, 0, BG, 0, 4'h0));
    step(mk(4'b0000, DEF, 0, 0, 0, 0, BG, 0, 4'h0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
